// File: rtl/cnt_disp_scan_if.sv
// Bundle of counter-side inputs and display-side outputs for cnt_disp_scan.
// The master drives the counter nibbles, carry and load; the slave (display back-end) drives the rest.
interface cnt_disp_scan_if;
    logic [3:0]  QH;
    logic [3:0]  QL;
    logic        C;
    logic        Load;
    logic        Busy;
    logic [11:0] Bcd;
    logic        Ovf;
    logic [6:0]  Seg;
    logic        Dp;
    logic [2:0]  Com;

    modport master (
        output QH, QL, C, Load,
        input  Busy, Bcd, Ovf, Seg, Dp, Com
    );

    modport slave (
        input  QH, QL, C, Load,
        output Busy, Bcd, Ovf, Seg, Dp, Com
    );
endinterface

// File: rtl/cnt_disp_scan.sv
// Display back-end for the 8-bit counter: binary-to-BCD conversion by shift-and-add-3,
// then a multiplexed 3-digit seven-segment scan with leading-zero blanking and a sticky overflow point.
module cnt_disp_scan #(
    parameter int SCAN_DIV       = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit COM_ACTIVE_LOW = 1'b1
) (
    input  logic            Clk,
    input  logic            MR,
    cnt_disp_scan_if.slave  bus
);

    localparam int       PW      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam bit [6:0] SEG_RST = SEG_ACTIVE_LOW ? 7'b1000000 : 7'b0111111;
    localparam bit [2:0] COM_RST = COM_ACTIVE_LOW ? 3'b110 : 3'b001;
    localparam bit       DP_RST  = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {IDLE, SHIFT, XFER} state_t;

    state_t        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [11:0]   scratch_q, scratch_d;
    logic [2:0]    iter_q, iter_d;
    logic [11:0]   bcd_q, bcd_d;
    logic          ovf_q, ovf_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    digit_q, digit_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [2:0]    com_q, com_d;

    logic          busy;
    logic [11:0]   scratch_adj;
    logic          presc_wrap;
    logic [3:0]    nibble;
    logic          blank;
    logic [6:0]    seg_lit;
    logic          dp_on;
    logic [2:0]    com_on;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    always_ff @(posedge Clk or posedge MR) begin
        if (MR) state_q <= IDLE;
        else    state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.Load) state_d = SHIFT;
            SHIFT:   if (iter_q == 3'd7) state_d = XFER;
            XFER:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
    end

    // Each nibble is corrected before the shift so it carries correctly into the next decade.
    assign scratch_adj = {add3(scratch_q[11:8]), add3(scratch_q[7:4]), add3(scratch_q[3:0])};

    always_comb begin
        shift_d   = shift_q;
        scratch_d = scratch_q;
        iter_d    = iter_q;
        bcd_d     = bcd_q;
        case (state_q)
            IDLE: begin
                if (bus.Load) begin
                    shift_d   = {bus.QH, bus.QL};
                    scratch_d = 12'h000;
                    iter_d    = 3'd0;
                end
            end
            SHIFT: begin
                {scratch_d, shift_d} = {scratch_adj, shift_q} << 1;
                iter_d               = iter_q + 3'd1;
            end
            XFER:    bcd_d = scratch_q;
            default: ;
        endcase
        ovf_d = ovf_q | bus.C;
    end

    assign presc_wrap = (presc_q == PW'(SCAN_DIV - 1));

    always_comb begin
        presc_d = presc_wrap ? '0 : presc_q + PW'(1);
        digit_d = digit_q;
        if (presc_wrap) digit_d = (digit_q == 2'd2) ? 2'd0 : digit_q + 2'd1;
    end

    // Display drive looks ahead to the digit being selected so Com and Seg change together.
    always_comb begin
        nibble = bcd_q[3:0];
        blank  = 1'b0;
        case (digit_d)
            2'd1: begin
                nibble = bcd_q[7:4];
                blank  = (bcd_q[11:4] == 8'h00);
            end
            2'd2: begin
                nibble = bcd_q[11:8];
                blank  = (bcd_q[11:8] == 4'h0);
            end
            default: ;
        endcase

        case (nibble)
            4'd0:    seg_lit = 7'b0111111;
            4'd1:    seg_lit = 7'b0000110;
            4'd2:    seg_lit = 7'b1011011;
            4'd3:    seg_lit = 7'b1001111;
            4'd4:    seg_lit = 7'b1100110;
            4'd5:    seg_lit = 7'b1101101;
            4'd6:    seg_lit = 7'b1111101;
            4'd7:    seg_lit = 7'b0000111;
            4'd8:    seg_lit = 7'b1111111;
            4'd9:    seg_lit = 7'b1101111;
            default: seg_lit = 7'b0000000;
        endcase
        if (blank) seg_lit = 7'b0000000;

        dp_on  = (digit_d == 2'd2) && ovf_q;
        com_on = 3'b001 << digit_d;

        seg_d = SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
        dp_d  = SEG_ACTIVE_LOW ? ~dp_on : dp_on;
        com_d = COM_ACTIVE_LOW ? ~com_on : com_on;
    end

    always_ff @(posedge Clk or posedge MR) begin
        if (MR) begin
            shift_q   <= 8'h00;
            scratch_q <= 12'h000;
            iter_q    <= 3'd0;
            bcd_q     <= 12'h000;
            ovf_q     <= 1'b0;
            presc_q   <= '0;
            digit_q   <= 2'd0;
            seg_q     <= SEG_RST;
            dp_q      <= DP_RST;
            com_q     <= COM_RST;
        end else begin
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            iter_q    <= iter_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            presc_q   <= presc_d;
            digit_q   <= digit_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            com_q     <= com_d;
        end
    end

    assign bus.Busy = busy;
    assign bus.Bcd  = bcd_q;
    assign bus.Ovf  = ovf_q;
    assign bus.Seg  = seg_q;
    assign bus.Dp   = dp_q;
    assign bus.Com  = com_q;

endmodule

// File: tb/tb_cnt_disp_scan.sv
// Bench for cnt_disp_scan with a short scan period; a timing-level model predicts
// conversion results by decimal arithmetic and the scan position by counting edges.
module tb_cnt_disp_scan;

    localparam int S = 4;

    logic Clk = 1'b0;
    logic MR  = 1'b0;
    int   checks = 0;
    int   errors = 0;

    cnt_disp_scan_if bus();

    cnt_disp_scan #(
        .SCAN_DIV       (S),
        .SEG_ACTIVE_LOW (1'b1),
        .COM_ACTIVE_LOW (1'b1)
    ) dut (
        .Clk (Clk),
        .MR  (MR),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    logic [6:0] digit_pat [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                                   7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

    function automatic logic [11:0] to_bcd(input logic [7:0] val);
        int v;
        v = val;
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Active-low segment pattern for a digit position, with leading zeros blanked.
    function automatic logic [6:0] exp_seg(input int idx, input logic [11:0] b);
        int h, t, u;
        logic [6:0] lit;
        h = b[11:8];
        t = b[7:4];
        u = b[3:0];
        if (idx == 0)      lit = digit_pat[u];
        else if (idx == 1) lit = (h == 0 && t == 0) ? 7'b0 : digit_pat[t];
        else               lit = (h == 0) ? 7'b0 : digit_pat[h];
        return ~lit;
    endfunction

    int          m_edges;
    int          m_left;
    logic [7:0]  m_val;
    logic [11:0] m_bcd;
    logic        m_ovf;
    logic [6:0]  m_seg;
    logic        m_dp;
    logic [2:0]  m_com;
    logic        m_busy;

    // A load starts a 9-edge busy window; the decimal result lands when it expires.
    always @(posedge Clk or posedge MR) begin
        if (MR) begin
            m_edges <= 0;
            m_left  <= 0;
            m_val   <= 8'h00;
            m_bcd   <= 12'h000;
            m_ovf   <= 1'b0;
            m_seg   <= exp_seg(0, 12'h000);
            m_dp    <= 1'b1;
            m_com   <= 3'b110;
        end else begin
            m_seg   <= exp_seg(((m_edges + 1) / S) % 3, m_bcd);
            m_dp    <= !((((m_edges + 1) / S) % 3 == 2) && m_ovf);
            m_com   <= ~(3'b001 << (((m_edges + 1) / S) % 3));
            m_edges <= m_edges + 1;
            if (bus.C) m_ovf <= 1'b1;
            if (m_left == 0) begin
                if (bus.Load) begin
                    m_val  <= {bus.QH, bus.QL};
                    m_left <= 9;
                end
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) m_bcd <= to_bcd(m_val);
            end
        end
    end

    assign m_busy = (m_left != 0);

    task automatic do_reset();
        MR = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        MR = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.Busy, bus.Bcd, bus.Ovf, bus.Com, bus.Seg, bus.Dp} !== {1'b0, 12'h000, 1'b0, 3'b110, 7'b1000000, 1'b1}) begin
            errors++;
            $display("[TB] FAIL reset_initial got busy=%b bcd=%h ovf=%b com=%b seg=%b dp=%b want 0 000 0 110 1000000 1",
                     bus.Busy, bus.Bcd, bus.Ovf, bus.Com, bus.Seg, bus.Dp);
        end
        bus.QH = 4'h3; bus.QL = 4'h9; bus.Load = 1'b1; bus.C = 1'b1;
        @(negedge Clk);
        bus.Load = 1'b0; bus.C = 1'b0;
        repeat (6) @(negedge Clk);
        checks++;
        if ({bus.Busy, bus.Ovf, bus.Com} !== {1'b1, 1'b1, 3'b101}) begin
            errors++;
            $display("[TB] FAIL reset_pre_state got busy=%b ovf=%b com=%b want 1 1 101", bus.Busy, bus.Ovf, bus.Com);
        end
        #2 MR = 1'b1;
        #1;
        checks++;
        if ({bus.Busy, bus.Bcd, bus.Ovf, bus.Com, bus.Seg, bus.Dp} !== {1'b0, 12'h000, 1'b0, 3'b110, 7'b1000000, 1'b1}) begin
            errors++;
            $display("[TB] FAIL reset_async got busy=%b bcd=%h ovf=%b com=%b seg=%b dp=%b want 0 000 0 110 1000000 1",
                     bus.Busy, bus.Bcd, bus.Ovf, bus.Com, bus.Seg, bus.Dp);
        end
        @(negedge Clk);
        MR = 1'b0;
    endtask

    task automatic test_load_ff();
        int busy_cycles;
        do_reset();
        bus.QH = 4'hF; bus.QL = 4'hF; bus.Load = 1'b1; bus.C = 1'b1;
        @(negedge Clk);
        bus.Load = 1'b0; bus.C = 1'b0; bus.QH = 4'h0; bus.QL = 4'h1;
        busy_cycles = 0;
        while (bus.Busy === 1'b1 && busy_cycles < 20) begin
            busy_cycles++;
            @(negedge Clk);
        end
        checks++;
        if (busy_cycles != 9) begin
            errors++;
            $display("[TB] FAIL ff_busy_len got %0d cycles want 9", busy_cycles);
        end
        checks++;
        if (bus.Bcd !== 12'h255) begin
            errors++;
            $display("[TB] FAIL ff_bcd got %h want 255", bus.Bcd);
        end
        checks++;
        if (bus.Ovf !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ff_ovf got %b want 1", bus.Ovf);
        end
    endtask

    task automatic test_ignore_load();
        do_reset();
        bus.QH = 4'h0; bus.QL = 4'h7; bus.Load = 1'b1;
        @(negedge Clk);
        bus.Load = 1'b0; bus.QH = 4'h9; bus.QL = 4'h9;
        repeat (2) @(negedge Clk);
        bus.Load = 1'b1;
        @(negedge Clk);
        bus.Load = 1'b0;
        repeat (6) @(negedge Clk);
        checks++;
        if ({bus.Busy, bus.Bcd} !== {1'b0, 12'h007}) begin
            errors++;
            $display("[TB] FAIL ignore_bcd got busy=%b bcd=%h want 0 007", bus.Busy, bus.Bcd);
        end
        @(negedge Clk);
        checks++;
        if (bus.Busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ignore_no_queue got busy=%b want 0", bus.Busy);
        end
        for (int i = 0; i < 3 * S; i++) begin
            checks++;
            if (bus.Com === 3'b110 && bus.Seg !== 7'b1111000) begin
                errors++;
                $display("[TB] FAIL units_seg got %b want 1111000", bus.Seg);
            end else if (bus.Com !== 3'b110 && bus.Seg !== 7'b1111111) begin
                errors++;
                $display("[TB] FAIL blank_seg com=%b got %b want 1111111", bus.Com, bus.Seg);
            end
            @(negedge Clk);
        end
    endtask

    task automatic test_scan();
        logic [2:0] prev_com;
        logic [2:0] exp_com;
        logic [6:0] exp_s;
        bit         found;
        do_reset();
        bus.QH = 4'h8; bus.QL = 4'h0; bus.Load = 1'b1;
        @(negedge Clk);
        bus.Load = 1'b0;
        repeat (9) @(negedge Clk);
        checks++;
        if (bus.Bcd !== 12'h128) begin
            errors++;
            $display("[TB] FAIL scan_bcd got %h want 128", bus.Bcd);
        end
        found = 1'b0;
        prev_com = bus.Com;
        for (int i = 0; i < 3 * S + 2 && !found; i++) begin
            @(negedge Clk);
            if (bus.Com === 3'b110 && prev_com !== 3'b110) found = 1'b1;
            else prev_com = bus.Com;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL scan_align got com=%b want transition to 110", bus.Com);
        end
        for (int i = 0; i < 3 * S; i++) begin
            if (i < S)          begin exp_com = 3'b110; exp_s = 7'b0000000; end
            else if (i < 2 * S) begin exp_com = 3'b101; exp_s = 7'b0100100; end
            else                begin exp_com = 3'b011; exp_s = 7'b1111001; end
            checks++;
            if ({bus.Com, bus.Seg, bus.Dp} !== {exp_com, exp_s, 1'b1}) begin
                errors++;
                $display("[TB] FAIL scan_step%0d got com=%b seg=%b dp=%b want %b %b 1", i, bus.Com, bus.Seg, bus.Dp, exp_com, exp_s);
            end
            @(negedge Clk);
        end
    endtask

    task automatic test_ovf_sticky();
        do_reset();
        bus.C = 1'b1;
        @(negedge Clk);
        bus.C = 1'b0;
        @(negedge Clk);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (bus.Ovf !== 1'b1 || bus.Dp !== (bus.Com === 3'b011 ? 1'b0 : 1'b1)) begin
                errors++;
                $display("[TB] FAIL ovf_sticky cycle %0d got ovf=%b dp=%b com=%b want ovf=1 dp lit only at 011",
                         i, bus.Ovf, bus.Dp, bus.Com);
            end
            @(negedge Clk);
        end
        #2 MR = 1'b1;
        #1;
        checks++;
        if ({bus.Ovf, bus.Dp} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL ovf_clear got ovf=%b dp=%b want 0 1", bus.Ovf, bus.Dp);
        end
        @(negedge Clk);
        MR = 1'b0;
    endtask

    task automatic test_abort();
        do_reset();
        bus.QH = 4'hC; bus.QL = 4'h8; bus.Load = 1'b1;
        @(negedge Clk);
        bus.Load = 1'b0;
        repeat (3) @(negedge Clk);
        checks++;
        if (bus.Busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_pre_busy got %b want 1", bus.Busy);
        end
        MR = 1'b1;
        #1;
        checks++;
        if ({bus.Busy, bus.Bcd} !== {1'b0, 12'h000}) begin
            errors++;
            $display("[TB] FAIL abort_state got busy=%b bcd=%h want 0 000", bus.Busy, bus.Bcd);
        end
        @(negedge Clk);
        MR = 1'b0;
        bus.Load = 1'b1;
        @(negedge Clk);
        bus.Load = 1'b0;
        repeat (8) @(negedge Clk);
        checks++;
        if ({bus.Busy, bus.Bcd} !== {1'b1, 12'h000}) begin
            errors++;
            $display("[TB] FAIL abort_reload_mid got busy=%b bcd=%h want 1 000", bus.Busy, bus.Bcd);
        end
        @(negedge Clk);
        checks++;
        if ({bus.Busy, bus.Bcd} !== {1'b0, 12'h200}) begin
            errors++;
            $display("[TB] FAIL abort_reload got busy=%b bcd=%h want 0 200", bus.Busy, bus.Bcd);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bus.QH   = 4'($urandom_range(0, 15));
            bus.QL   = 4'($urandom_range(0, 15));
            bus.Load = ($urandom_range(0, 3) == 0);
            bus.C    = ($urandom_range(0, 40) == 0);
            @(negedge Clk);
            checks++;
            if ({bus.Busy, bus.Bcd, bus.Ovf, bus.Com, bus.Seg, bus.Dp} !== {m_busy, m_bcd, m_ovf, m_com, m_seg, m_dp}) begin
                errors++;
                $display("[TB] FAIL random cycle %0d got busy=%b bcd=%h ovf=%b com=%b seg=%b dp=%b want %b %h %b %b %b %b",
                         i, bus.Busy, bus.Bcd, bus.Ovf, bus.Com, bus.Seg, bus.Dp,
                         m_busy, m_bcd, m_ovf, m_com, m_seg, m_dp);
            end
        end
        bus.Load = 1'b0;
        bus.C    = 1'b0;
    endtask

    initial begin
        bus.QH = 4'h0; bus.QL = 4'h0; bus.C = 1'b0; bus.Load = 1'b0;
        #1 MR = 1'b1;
        test_reset();
        test_load_ff();
        test_ignore_load();
        test_scan();
        test_ovf_sticky();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
